// File: rtl/demux_1x4_buf.sv
// 1-to-4 buffered demultiplexer: routes f to one of four channels, each with its own
// valid/ready handshake. Define DEMUX_DEPTH2_EN for 2-entry channel FIFOs (default: 1 entry).
module demux_1x4_buf (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] f,
  input  logic       s1,
  input  logic       s0,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] o0,
  output logic [7:0] o1,
  output logic [7:0] o2,
  output logic [7:0] o3,
  output logic       v0,
  output logic       v1,
  output logic       v2,
  output logic       v3,
  input  logic       r0,
  input  logic       r1,
  input  logic       r2,
  input  logic       r3
);

  logic [1:0] sel;
  logic [3:0] r_all;
  logic [3:0] valid_all;
  logic [3:0] space_all;
  logic [3:0] push_all;
  logic [3:0] pop_all;
  logic [7:0] data_all [4];

  assign sel   = {s1, s0};
  assign r_all = {r3, r2, r1, r0};

  // A full channel still accepts when its head leaves on the same edge.
  assign in_ready = space_all[sel] | r_all[sel];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_chan
      assign push_all[gi] = in_valid & in_ready & (sel == 2'(gi));
      assign pop_all[gi]  = valid_all[gi] & r_all[gi];

`ifdef DEMUX_DEPTH2_EN
      logic [7:0] mem_reg [2];
      logic       wr_ptr_reg;
      logic       rd_ptr_reg;
      logic [1:0] count_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          mem_reg[0] <= 8'h00;
          mem_reg[1] <= 8'h00;
          wr_ptr_reg <= 1'b0;
          rd_ptr_reg <= 1'b0;
          count_reg  <= 2'd0;
        end else begin
          if (push_all[gi]) begin
            mem_reg[wr_ptr_reg] <= f;
          end
          // Popping the last word leaves rd_ptr on it so the output keeps its last value;
          // the write pointer is pulled back so the next word lands in that same slot.
          if (pop_all[gi] && !push_all[gi] && count_reg == 2'd1) begin
            wr_ptr_reg <= rd_ptr_reg;
          end else begin
            if (push_all[gi]) wr_ptr_reg <= ~wr_ptr_reg;
            if (pop_all[gi])  rd_ptr_reg <= ~rd_ptr_reg;
          end
          case ({push_all[gi], pop_all[gi]})
            2'b10:   count_reg <= count_reg + 2'd1;
            2'b01:   count_reg <= count_reg - 2'd1;
            default: count_reg <= count_reg;
          endcase
        end
      end

      assign valid_all[gi] = (count_reg != 2'd0);
      assign space_all[gi] = (count_reg != 2'd2);
      assign data_all[gi]  = mem_reg[rd_ptr_reg];
`else
      logic [7:0] data_reg;
      logic       full_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          data_reg <= 8'h00;
          full_reg <= 1'b0;
        end else begin
          if (push_all[gi]) begin
            data_reg <= f;
            full_reg <= 1'b1;
          end else if (pop_all[gi]) begin
            full_reg <= 1'b0;
          end
        end
      end

      assign valid_all[gi] = full_reg;
      assign space_all[gi] = ~full_reg;
      assign data_all[gi]  = data_reg;
`endif
    end
  endgenerate

  assign o0 = data_all[0];
  assign o1 = data_all[1];
  assign o2 = data_all[2];
  assign o3 = data_all[3];
  assign v0 = valid_all[0];
  assign v1 = valid_all[1];
  assign v2 = valid_all[2];
  assign v3 = valid_all[3];

endmodule

// File: tb/tb_demux_1x4_buf.sv
// Scoreboard bench for demux_1x4_buf: directed vectors plus a random phase; build with
// DEMUX_DEPTH2_EN defined to exercise the 2-entry channels.
module tb_demux_1x4_buf;

`ifdef DEMUX_DEPTH2_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] f;
  logic [1:0] sel;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] o [4];
  logic [3:0] v;
  logic [3:0] r;

  int vectors    = 0;
  int miscompares = 0;

  logic [7:0] exp_q [4][$];

  demux_1x4_buf dut (
    .clk(clk), .rst(rst), .f(f), .s1(sel[1]), .s0(sel[0]),
    .in_valid(in_valid), .in_ready(in_ready),
    .o0(o[0]), .o1(o[1]), .o2(o[2]), .o3(o[3]),
    .v0(v[0]), .v1(v[1]), .v2(v[2]), .v3(v[3]),
    .r0(r[0]), .r1(r[1]), .r2(r[2]), .r3(r[3])
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: sampled mid-cycle, these are exactly the values the next rising edge acts on.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("v%0d", k), 32'(v[k]), 32'(exp_q[k].size() != 0));
        if (exp_q[k].size() != 0)
          chk($sformatf("o%0d", k), 32'(o[k]), 32'(exp_q[k][0]));
      end
      chk("in_ready", 32'(in_ready), 32'((exp_q[sel].size() < DEPTH) || r[sel]));
      for (int k = 0; k < 4; k++)
        if (v[k] && r[k] && exp_q[k].size() != 0) void'(exp_q[k].pop_front());
      if (in_valid && in_ready) exp_q[sel].push_back(f);
    end
  end

  // Drive one word and return at the mid-cycle point just before the accepting edge.
  task automatic send(input logic [1:0] ch, input logic [7:0] data);
    int wait_cycles = 0;
    @(posedge clk); #1;
    sel = ch; f = data; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      wait_cycles++;
      if (wait_cycles > 100) begin
        chk("send_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        return;
      end
    end
    $display("push ch%0d data %02h", ch, data);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic set_r(input logic [3:0] val, input int cycles);
    @(posedge clk); #1;
    r = val;
    repeat (cycles) @(posedge clk);
    #1 r = 4'h0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; sel = 2'd0; f = 8'h00; r = 4'h0;
    #2;
    chk("reset_v", 32'(v), 32'h0);
    for (int k = 0; k < 4; k++) chk($sformatf("reset_o%0d", k), 32'(o[k]), 32'h00);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1 rst = 1'b0;

    // Routing to all four channels on consecutive cycles.
    send(2'd0, 8'h11); send(2'd1, 8'h22); send(2'd2, 8'h33); send(2'd3, 8'h44);
    idle();
    @(negedge clk);
    chk("route_v", 32'(v), 32'hF);
    chk("route_o0", 32'(o[0]), 32'h11);
    chk("route_o1", 32'(o[1]), 32'h22);
    chk("route_o2", 32'(o[2]), 32'h33);
    chk("route_o3", 32'(o[3]), 32'h44);

    // Backpressure on channel 1, then re-select channel 3 while still valid.
    set_r(4'b1101, 2);
`ifdef DEMUX_DEPTH2_EN
    send(2'd1, 8'h66);
    idle();
`endif
    @(posedge clk); #1;
    sel = 2'd1; f = 8'h55; in_valid = 1'b1;
    @(negedge clk);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_o1", 32'(o[1]), 32'h22);
    @(posedge clk); #1 sel = 2'd3;
    @(negedge clk);
    chk("bp_sel3_ready", 32'(in_ready), 32'd1);
    idle();
    @(negedge clk);
    chk("bp_o3", 32'(o[3]), 32'h55);
    set_r(4'hF, 3);

    // Push and pop on the same edge into a holding channel 0.
    send(2'd0, 8'h10);
    idle();
    @(posedge clk); #1;
    r = 4'b0001; sel = 2'd0; f = 8'h20; in_valid = 1'b1;
    @(posedge clk); #1;
    r = 4'h0; in_valid = 1'b0;
    @(negedge clk);
    chk("pp_o0", 32'(o[0]), 32'h20);
    chk("pp_v0", 32'(v[0]), 32'd1);
    set_r(4'hF, 2);

    // Fill channel 2, then drain it and check the output holds its last word.
    send(2'd2, 8'hAA);
`ifdef DEMUX_DEPTH2_EN
    send(2'd2, 8'hBB);
`endif
    idle();
    sel = 2'd2;
    @(negedge clk);
    chk("fill_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1 r = 4'b0100;
    @(negedge clk);
    chk("drain_first", 32'(o[2]), 32'hAA);
    @(negedge clk);
`ifdef DEMUX_DEPTH2_EN
    chk("drain_second", 32'(o[2]), 32'hBB);
    @(negedge clk);
    chk("drain_v2", 32'(v[2]), 32'd0);
    chk("drain_hold", 32'(o[2]), 32'hBB);
`else
    chk("drain_v2", 32'(v[2]), 32'd0);
    chk("drain_hold", 32'(o[2]), 32'hAA);
`endif
    @(posedge clk); #1 r = 4'h0;

    // Asynchronous reset in the middle of a cycle with data buffered.
    send(2'd2, 8'hA5);
    idle();
    @(posedge clk); #3 rst = 1'b1;
    #1;
    chk("arst_v", 32'(v), 32'h0);
    for (int k = 0; k < 4; k++) chk($sformatf("arst_o%0d", k), 32'(o[k]), 32'h00);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    for (int k = 0; k < 4; k++) exp_q[k].delete();
    @(posedge clk); #1 rst = 1'b0;

    // Random traffic; the monitor checks order, loss and duplication.
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      in_valid = 1'($urandom_range(0, 1));
      sel = 2'($urandom_range(0, 3));
      f = 8'($urandom_range(0, 255));
      r = 4'($urandom_range(0, 15));
    end
    @(posedge clk); #1;
    in_valid = 1'b0; r = 4'hF;
    repeat (4) @(posedge clk);
    #1 r = 4'h0;
    @(negedge clk);
    chk("final_v", 32'(v), 32'h0);
    for (int k = 0; k < 4; k++) chk($sformatf("final_q%0d", k), 32'(exp_q[k].size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
